// File: rtl/mux_scan_collector.sv
// Scan collector for an 8:1 mux: steps the select code, samples the
// mux output per code and presents the recovered word on O0..O7.
module mux_scan_collector (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic start,
  input  logic we,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic O0,
  output logic O1,
  output logic O2,
  output logic O3,
  output logic O4,
  output logic O5,
  output logic O6,
  output logic O7,
  output logic busy,
  output logic valid
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [6:0] shadow;
  logic [7:0] o_q;
  logic [2:0] addr;
  logic [2:0] sel;

  assign addr = {A2, A1, A0};

  // Select follows the counter only while collecting
  always_comb begin
    sel  = 3'b000;
    busy = 1'b0;
    if (state == COLLECT) begin
      sel  = cnt;
      busy = 1'b1;
    end
  end

  assign S0 = sel[0];
  assign S1 = sel[1];
  assign S2 = sel[2];

  assign O0 = o_q[0];
  assign O1 = o_q[1];
  assign O2 = o_q[2];
  assign O3 = o_q[3];
  assign O4 = o_q[4];
  assign O5 = o_q[5];
  assign O6 = o_q[6];
  assign O7 = o_q[7];

  // Frame sequencer, shadow capture and output word update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      shadow <= 7'd0;
      o_q    <= 8'd0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= COLLECT;
            cnt   <= 3'd0;
          end else if (we) begin
            o_q[addr] <= din;
          end
        end
        COLLECT: begin
          if (cnt == 3'd7) begin
            o_q   <= {din, shadow};
            valid <= 1'b1;
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            for (int i = 0; i < 7; i++) begin
              if (cnt == 3'(i)) shadow[i] <= din;
            end
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
